gouram_trace_packetiser: RTL and testbench
==========================================

# gouram_trace_packetiser

Downstream consumer of the Gouram trace unit's completed-instruction records. Each cycle it can accept one packed `trace_format` record, tagged with a valid strobe. Accepted records are queued in an internal FIFO and serialised into a framed stream of `WORD_WIDTH` words under a valid/ready handshake, for an off-chip link or a DMA. Records that arrive while the FIFO is full are dropped and counted, and sequence numbers make the resulting gaps visible downstream.

## Interface
- `TRACE_WIDTH`, default 128: bit width of one packed `trace_format` record.
- `DEPTH`, default 16: FIFO depth in records, power of two, ≥ 2.
- `WORD_WIDTH`, default 32: output word width, fixed at 32 by the header format.
- Derived `NWORDS` = ceil(`TRACE_WIDTH`/`WORD_WIDTH`), which must be ≤ 255.

Ports:
- `clk` in, 1 bit: single clock; all logic is clocked on the rising edge.
- `rst` in, 1 bit: asynchronous, active-low reset.
- `trace_valid_i` in, 1 bit: a record is presented this cycle.
- `trace_data_i` in, `TRACE_WIDTH` bits: packed `trace_format` record.
- `out_valid_o` out, 1 bit: `out_data_o` holds a valid word.
- `out_data_o` out, 32 bits: header or payload word.
- `out_last_o` out, 1 bit: the current word is the final word of its packet.
- `out_ready_i` in, 1 bit: the sink accepts a word.
- `fifo_level_o` out, $clog2(DEPTH)+1 bits: number of records held in the FIFO, excluding the one being serialised.
- `overflow_o` out, 1 bit: sticky flag, set on the first dropped record.
- `overflow_count_o` out, 16 bits: dropped-record count, saturates at 0xFFFF.

## Operation
- **Sequence counter.** An 8-bit `seq` counter increments on every cycle with `trace_valid_i`=1, whether the record is accepted or dropped. It wraps from 255 to 0. An accepted record is stored together with the `seq` value from before the increment.
- **Push.** A push occurs when `trace_valid_i`=1 and either the FIFO is not full, or a pop happens in the same cycle.
- **Drop.** If the FIFO is full and no pop happens that cycle, the record is dropped:
  - `overflow_count_o` increments, saturating at 0xFFFF;
  - `overflow_o` is set to 1.
- **Packet format.**
  - Header word: [31:24]=0xA5, [23:16]=seq, [15:8]=NWORDS, [7:0]=0.
  - Then NWORDS payload words. Word k carries `trace_data_i`[32k+31:32k]; bits above `TRACE_WIDTH` in the last word are zero.
- **State machine**, states IDLE / HEADER / PAYLOAD:
  - **IDLE:** `out_valid_o`=0. If the FIFO is non-empty, pop the head into the output shift register and go to HEADER. The pop does not depend on `out_ready_i`.
  - **HEADER:** `out_valid_o`=1. On a transfer (valid & ready), clear the word index and go to PAYLOAD.
  - **PAYLOAD:** `out_valid_o`=1.
    - `out_last_o`=1 when the index equals NWORDS-1.
    - On a transfer with index < NWORDS-1, increment the index.
    - On a transfer of the last word with the FIFO non-empty, pop, load the next record and go directly to HEADER. There is no idle cycle between packets.
    - On a transfer of the last word with the FIFO empty, go to IDLE.
- **Handshake.** While `out_valid_o`=1 and `out_ready_i`=0, `out_data_o` and `out_last_o` hold stable. `out_valid_o` never drops before a transfer.
- **Reset.** With `rst`=0, all state clears asynchronously:
  - all outputs go to 0;
  - FIFO empty, `seq`=0, state IDLE, overflow count and flag cleared.
  - A packet in flight is abandoned with no `out_last_o`.
  - The block resumes on the first clock edge after `rst` returns to 1.

## Timing
- **Latency.** A record pushed at edge N into an empty block with the FSM in IDLE is popped at edge N+1. Its header appears with `out_valid_o`=1 after edge N+1, one cycle later than the push.
- **Throughput.** One packet per NWORDS+1 cycles when `out_ready_i` is held at 1.
- **Levels.** `fifo_level_o`, `overflow_o` and `overflow_count_o` are registered and update at the edge of the push, pop or drop.
- **Push and pop in the same cycle.**
  - If not full, the level is unchanged.
  - If full, the push is accepted and the level stays at DEPTH.
- **FIFO pointers.** Read and write pointers are $clog2(DEPTH) bits and wrap naturally. Full and empty are derived from an occupancy counter.

## Test plan
- **Single record, no back-pressure.** Defaults, `out_ready_i`=1, one record 0x0123…CDEF at seq 0. The stream must be 0xA5000400, then words [31:0], [63:32], [95:64], [127:96]. `out_last_o`=1 only on the 4th payload word. Header valid 1 cycle after the push.
- **Back-pressure.** Toggle `out_ready_i` every cycle during a packet. Each word must hold stable until accepted, and no words may be lost or duplicated.
- **Overflow.** `out_ready_i`=0, DEPTH=16, 20 consecutive records.
  - 17 records accepted: 1 in the shift register, `fifo_level_o`=16.
  - `overflow_count_o`=3, `overflow_o`=1.
  - After ready is raised, headers carry seq 0..16.
  - The next accepted record carries seq 20.
- **Sequence wrap.** 300 records with `out_ready_i`=1, spaced 5 cycles apart. Header seq must run 0..255, then 0..43, with no drops.
- **Back-to-back packets.** Two records pushed on consecutive cycles with ready=1. The second header must follow the first packet's last word on the very next cycle.
- **Reset mid-packet.** Assert `rst`=0 after the 2nd payload word. All outputs must be 0 immediately. After release, a new record emits a header with seq 0.

Source files
------------

// File: rtl/gouram_trace_packetiser.sv
// Queues completed-instruction trace records and serialises each one as a
// framed packet: one header word, then NWORDS payload words, under valid/ready.
module gouram_trace_packetiser #(
  parameter int TRACE_WIDTH = 128,
  parameter int DEPTH       = 16,
  parameter int WORD_WIDTH  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      trace_valid_i,
  input  logic [TRACE_WIDTH-1:0]    trace_data_i,
  output logic                      out_valid_o,
  output logic [WORD_WIDTH-1:0]     out_data_o,
  output logic                      out_last_o,
  input  logic                      out_ready_i,
  output logic [$clog2(DEPTH):0]    fifo_level_o,
  output logic                      overflow_o,
  output logic [15:0]               overflow_count_o
);
  localparam int NWORDS = (TRACE_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int AW     = $clog2(DEPTH);
  localparam int LW     = AW + 1;
  localparam int SW     = NWORDS * WORD_WIDTH;

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;
  typedef struct packed {
    logic [7:0]             seq;
    logic [TRACE_WIDTH-1:0] data;
  } rec_t;

  state_t          state, nstate;
  rec_t            mem [DEPTH];
  rec_t            head;
  logic [AW-1:0]   wptr, rptr;
  logic [LW-1:0]   count;
  logic [7:0]      seq, cur_seq, idx;
  logic [SW-1:0]   sh;
  logic            empty, full, push, pop, drop, xfer, last;

  assign empty = (count == '0);
  assign full  = (count == LW'(DEPTH));
  assign head  = mem[rptr];
  assign xfer  = out_valid_o & out_ready_i;
  assign last  = (idx == 8'(NWORDS - 1));
  // Popping is independent of the sink in IDLE; in PAYLOAD it rides on the last-word transfer.
  assign pop   = ~empty & ((state == IDLE) | ((state == PAYLOAD) & xfer & last));
  assign push  = trace_valid_i & (~full | pop);
  assign drop  = trace_valid_i & full & ~pop;

  assign fifo_level_o = count;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= '{seq: seq, data: trace_data_i};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr             <= '0;
      rptr             <= '0;
      count            <= '0;
      seq              <= '0;
      overflow_o       <= 1'b0;
      overflow_count_o <= '0;
    end else begin
      if (trace_valid_i) seq <= seq + 8'd1;
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      if (push && !pop)      count <= count + LW'(1);
      else if (pop && !push) count <= count - LW'(1);
      if (drop) begin
        overflow_o <= 1'b1;
        if (overflow_count_o != 16'hFFFF) overflow_count_o <= overflow_count_o + 16'd1;
      end
    end
  end

  // Output shift register: payload word 0 always sits in the low bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh      <= '0;
      cur_seq <= '0;
      idx     <= '0;
    end else begin
      if (pop) begin
        sh      <= SW'(head.data);
        cur_seq <= head.seq;
      end else if (state == PAYLOAD && xfer && !last) begin
        sh  <= sh >> WORD_WIDTH;
        idx <= idx + 8'd1;
      end
      if (state == HEADER && xfer) idx <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (!empty) nstate = HEADER;
      HEADER:  if (xfer) nstate = PAYLOAD;
      PAYLOAD: if (xfer && last) nstate = empty ? IDLE : HEADER;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    out_valid_o = 1'b0;
    out_last_o  = 1'b0;
    out_data_o  = '0;
    case (state)
      HEADER: begin
        out_valid_o = 1'b1;
        out_data_o  = {8'hA5, cur_seq, 8'(NWORDS), 8'h00};
      end
      PAYLOAD: begin
        out_valid_o = 1'b1;
        out_last_o  = last;
        out_data_o  = sh[WORD_WIDTH-1:0];
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_gouram_trace_packetiser.sv
// Bench for gouram_trace_packetiser at default parameters: cycle table plus
// overflow, reset-mid-packet and sequence-wrap sequences.
module tb_gouram_trace_packetiser;
  localparam int NW = 4;
  localparam logic [127:0] D1 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] D2 = 128'hDEADBEEF_CAFEF00D_13579BDF_2468ACE0;
  localparam logic [127:0] D3 = 128'h55555555_AAAAAAAA_0F0F0F0F_F0F0F0F0;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         trace_valid_i = 1'b0;
  logic [127:0] trace_data_i = '0;
  logic         out_valid_o, out_last_o;
  logic [31:0]  out_data_o;
  logic         out_ready_i = 1'b0;
  logic [4:0]   fifo_level_o;
  logic         overflow_o;
  logic [15:0]  overflow_count_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  gouram_trace_packetiser dut (
    .clk(clk), .rst(rst),
    .trace_valid_i(trace_valid_i), .trace_data_i(trace_data_i),
    .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_last_o(out_last_o),
    .out_ready_i(out_ready_i), .fifo_level_o(fifo_level_o),
    .overflow_o(overflow_o), .overflow_count_o(overflow_count_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  typedef struct {
    logic         v;
    logic [127:0] d;
    logic         r;
    logic         ev;
    logic [31:0]  ed;
    logic         el;
    logic [4:0]   elv;
  } vec_t;

  vec_t tbl [32];

  function automatic vec_t mk(logic v, logic [127:0] d, logic r,
                              logic ev, logic [31:0] ed, logic el, logic [4:0] elv);
    mk = '{v: v, d: d, r: r, ev: ev, ed: ed, el: el, elv: elv};
  endfunction

  task automatic chk(input string nm, input logic [159:0] got, input logic [159:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", nm, got, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; trace_valid_i = 1'b0; trace_data_i = '0; out_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic push(input logic [127:0] d);
    trace_valid_i = 1'b1; trace_data_i = d;
    step();
    trace_valid_i = 1'b0; trace_data_i = '0;
  endtask

  // Collects one packet with whatever ready level the caller drives.
  task automatic get_pkt(output logic [7:0] s, output logic [127:0] d, output logic ok);
    int n;
    n = 0; ok = 1'b0; s = '0; d = '0;
    for (int c = 0; c < 200 && n <= NW; c++) begin
      @(negedge clk);
      if (out_valid_o && out_ready_i) begin
        if (n == 0) begin
          s  = out_data_o[23:16];
          ok = (out_data_o[31:24] == 8'hA5) && (out_data_o[15:0] == 16'h0400) && !out_last_o;
        end else begin
          d[(n-1)*32 +: 32] = out_data_o;
          if (out_last_o != (n == NW)) ok = 1'b0;
        end
        n++;
      end
      @(posedge clk); #1;
    end
    if (n <= NW) ok = 1'b0;
  endtask

  initial begin
    logic [7:0]   s;
    logic [127:0] d;
    logic         ok;

    tbl[0]  = mk(1, D1, 1, 0, 32'h0, 0, 0);
    tbl[1]  = mk(0, 0,  1, 0, 32'h0, 0, 1);
    tbl[2]  = mk(0, 0,  1, 1, 32'hA5000400, 0, 0);
    tbl[3]  = mk(0, 0,  1, 1, 32'h76543210, 0, 0);
    tbl[4]  = mk(0, 0,  1, 1, 32'hFEDCBA98, 0, 0);
    tbl[5]  = mk(0, 0,  1, 1, 32'h89ABCDEF, 0, 0);
    tbl[6]  = mk(0, 0,  1, 1, 32'h01234567, 1, 0);
    tbl[7]  = mk(1, D2, 0, 0, 32'h0, 0, 0);
    tbl[8]  = mk(0, 0,  0, 0, 32'h0, 0, 1);
    tbl[9]  = mk(0, 0,  0, 1, 32'hA5010400, 0, 0);
    tbl[10] = mk(0, 0,  1, 1, 32'hA5010400, 0, 0);
    tbl[11] = mk(0, 0,  0, 1, 32'h2468ACE0, 0, 0);
    tbl[12] = mk(0, 0,  1, 1, 32'h2468ACE0, 0, 0);
    tbl[13] = mk(0, 0,  0, 1, 32'h13579BDF, 0, 0);
    tbl[14] = mk(0, 0,  1, 1, 32'h13579BDF, 0, 0);
    tbl[15] = mk(0, 0,  0, 1, 32'hCAFEF00D, 0, 0);
    tbl[16] = mk(0, 0,  1, 1, 32'hCAFEF00D, 0, 0);
    tbl[17] = mk(0, 0,  0, 1, 32'hDEADBEEF, 1, 0);
    tbl[18] = mk(0, 0,  1, 1, 32'hDEADBEEF, 1, 0);
    tbl[19] = mk(1, D1, 1, 0, 32'h0, 0, 0);
    tbl[20] = mk(1, D2, 1, 0, 32'h0, 0, 1);
    tbl[21] = mk(0, 0,  1, 1, 32'hA5020400, 0, 1);
    tbl[22] = mk(0, 0,  1, 1, 32'h76543210, 0, 1);
    tbl[23] = mk(0, 0,  1, 1, 32'hFEDCBA98, 0, 1);
    tbl[24] = mk(0, 0,  1, 1, 32'h89ABCDEF, 0, 1);
    tbl[25] = mk(0, 0,  1, 1, 32'h01234567, 1, 1);
    tbl[26] = mk(0, 0,  1, 1, 32'hA5030400, 0, 0);
    tbl[27] = mk(0, 0,  1, 1, 32'h2468ACE0, 0, 0);
    tbl[28] = mk(0, 0,  1, 1, 32'h13579BDF, 0, 0);
    tbl[29] = mk(0, 0,  1, 1, 32'hCAFEF00D, 0, 0);
    tbl[30] = mk(0, 0,  1, 1, 32'hDEADBEEF, 1, 0);
    tbl[31] = mk(0, 0,  1, 0, 32'h0, 0, 0);

    #3;
    chk("reset_state", 160'({out_valid_o, out_data_o, out_last_o, fifo_level_o, overflow_o, overflow_count_o}), 160'(0));
    do_reset();

    // Single packet, back-pressure and back-to-back packets, cycle by cycle.
    for (int i = 0; i < 32; i++) begin
      trace_valid_i = tbl[i].v; trace_data_i = tbl[i].d; out_ready_i = tbl[i].r;
      @(negedge clk);
      chk($sformatf("row%0d", i),
          160'({out_valid_o, out_data_o, out_last_o, fifo_level_o}),
          160'({tbl[i].ev, tbl[i].ed, tbl[i].el, tbl[i].elv}));
      step();
    end
    trace_valid_i = 1'b0; trace_data_i = '0;

    // Overflow: 20 records against a stalled sink; 17 fit, 3 dropped.
    do_reset();
    out_ready_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      trace_valid_i = 1'b1; trace_data_i = 128'(i);
      step();
    end
    trace_valid_i = 1'b0; trace_data_i = '0;
    @(negedge clk);
    chk("ovf_level", 160'(fifo_level_o), 160'(16));
    chk("ovf_count", 160'(overflow_count_o), 160'(3));
    chk("ovf_flag", 160'(overflow_o), 160'(1));
    step();
    out_ready_i = 1'b1;
    for (int k = 0; k < 17; k++) begin
      get_pkt(s, d, ok);
      chk($sformatf("ovf_pkt%0d", k), {23'd0, ok, s, d}, {23'd0, 1'b1, 8'(k), 128'(k)});
    end
    chk("ovf_drained", 160'(fifo_level_o), 160'(0));
    push(128'd100);
    get_pkt(s, d, ok);
    chk("ovf_next_seq", {23'd0, ok, s, d}, {23'd0, 1'b1, 8'd20, 128'd100});
    chk("ovf_sticky", 160'({overflow_o, overflow_count_o}), 160'({1'b1, 16'd3}));

    // Reset in the middle of a packet, with a second record still queued.
    trace_valid_i = 1'b1; trace_data_i = D1; step();
    trace_data_i = D2; step();
    trace_valid_i = 1'b0; trace_data_i = '0;
    repeat (3) step();
    chk("pre_rst_word", 160'({out_valid_o, out_data_o, fifo_level_o}), 160'({1'b1, 32'h89ABCDEF, 5'd1}));
    rst = 1'b0;
    #1;
    chk("mid_rst_outputs", 160'({out_valid_o, out_data_o, out_last_o, fifo_level_o, overflow_o, overflow_count_o}), 160'(0));
    @(posedge clk); #1 rst = 1'b1;
    push(D3);
    get_pkt(s, d, ok);
    chk("post_rst_pkt", {23'd0, ok, s, d}, {23'd0, 1'b1, 8'd0, D3});
    chk("post_rst_idle", 160'({out_valid_o, fifo_level_o}), 160'(0));

    // Sequence wrap: 300 records, 5 cycles apart, sink always ready.
    do_reset();
    out_ready_i = 1'b1;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          trace_valid_i = 1'b1; trace_data_i = 128'(i);
          step();
          trace_valid_i = 1'b0; trace_data_i = '0;
          repeat (4) step();
        end
      end
      begin
        logic [7:0]   ws;
        logic [127:0] wd;
        logic         wok;
        for (int i = 0; i < 300; i++) begin
          get_pkt(ws, wd, wok);
          chk($sformatf("wrap_pkt%0d", i), {23'd0, wok, ws, wd}, {23'd0, 1'b1, 8'(i % 256), 128'(i)});
        end
      end
    join
    chk("wrap_no_drops", 160'({overflow_o, overflow_count_o}), 160'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
